// File: rtl/ones_result_fifo.sv
// rtl/ones_result_fifo.sv - result FIFO capturing popcount results on done rising edges
//
// Purpose: stores each upstream popcount result (captured on the rising edge
// of done) in a small circular FIFO, hands entries to a consumer with a
// one-cycle registered read, and flags dropped results with a sticky
// overflow bit. Optional running total enabled by macro ONES_TOTAL_EN.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - asynchronous active-low reset
//   bit_count  - popcount result from the upstream ones counter
//   done       - upstream completion flag, level-high while result is held
//   clr        - synchronous clear of pointers, level, overflow, total
//   rd_en      - consumer pop request
//   rd_data    - popped result, registered
//   rd_valid   - one-cycle pulse marking rd_data updated
//   empty      - FIFO empty
//   full       - FIFO full
//   level      - current entry count
//   overflow   - sticky flag, a result was dropped while full
//   total      - saturating sum of accepted results (ONES_TOTAL_EN only)

module ones_result_fifo #(
   parameter int counter_size = 3,
   parameter int fifo_depth   = 4,
   parameter int total_size   = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [counter_size-1:0]         bit_count,
   input  logic                            done,
   input  logic                            clr,
   input  logic                            rd_en,
   output logic [counter_size-1:0]         rd_data,
   output logic                            rd_valid,
   output logic                            empty,
   output logic                            full,
   output logic [$clog2(fifo_depth):0]     level,
   output logic                            overflow
`ifdef ONES_TOTAL_EN
   ,
   output logic [total_size-1:0]           total
`endif
);

   localparam int aw = $clog2(fifo_depth);
   localparam int lw = aw + 1;

   logic [counter_size-1:0] mem [fifo_depth];
   logic [aw-1:0]           wr_ptr;
   logic [aw-1:0]           rd_ptr;
   logic                    done_q;
   logic                    init_q;
   logic                    capture;
   logic                    pop;
   logic                    push;
   logic                    drop;

   assign empty = (level == '0);
   assign full  = (level == lw'(fifo_depth));

   // init_q masks the first cycle after reset release so a done that was
   // already high is seen as "already captured" (done_q effectively 1).
   assign capture = done & ~done_q & ~init_q;

   // clr wins over everything else; an empty FIFO never pops, so a capture
   // into an empty FIFO cannot bypass to rd_data.
   assign pop  = rd_en & ~empty & ~clr;
   assign push = capture & (~full | pop) & ~clr;
   assign drop = capture & full & ~pop & ~clr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done_q   <= 1'b0;
         init_q   <= 1'b1;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         done_q <= done;
         init_q <= 1'b0;
         if (clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            rd_valid <= 1'b0;
         end else begin
            rd_valid <= pop;
            if (pop) begin
               rd_data <= mem[rd_ptr];
               rd_ptr  <= rd_ptr + aw'(1);
            end
            if (push) begin
               wr_ptr <= wr_ptr + aw'(1);
            end
            case ({push, pop})
               2'b10:   level <= level + lw'(1);
               2'b01:   level <= level - lw'(1);
               default: level <= level;
            endcase
            if (drop) begin
               overflow <= 1'b1;
            end
         end
      end
   end

   // Storage is not reset: clearing level and pointers discards the entries.
   // When full with a simultaneous pop, wr_ptr equals rd_ptr; the read above
   // samples the old entry before this write lands.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bit_count;
      end
   end

`ifdef ONES_TOTAL_EN
   localparam int tw = total_size + 1;

   logic [tw-1:0] total_sum;

   assign total_sum = {1'b0, total} + tw'(bit_count);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         total <= '0;
      end else if (clr) begin
         total <= '0;
      end else if (push) begin
         total <= total_sum[total_size] ? '1 : total_sum[total_size-1:0];
      end
   end
`endif

endmodule

// File: tb/tb_ones_result_fifo.sv
// tb/tb_ones_result_fifo.sv - directed self-checking bench for ones_result_fifo

module tb_ones_result_fifo;

   localparam int cs = 3;
   localparam int depth = 4;
   localparam int ts = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [cs-1:0] bit_count = '0;
   logic          done = 1'b0;
   logic          clr = 1'b0;
   logic          rd_en = 1'b0;
   logic [cs-1:0] rd_data;
   logic          rd_valid;
   logic          empty;
   logic          full;
   logic [2:0]    level;
   logic          overflow;
`ifdef ONES_TOTAL_EN
   logic [ts-1:0] total;
`endif

   int errors = 0;
   int checks = 0;
   int mlevel = 0;
   logic movf = 1'b0;
   logic [cs-1:0] mlast = '0;
   logic [cs-1:0] sb [$];

   ones_result_fifo #(
      .counter_size(cs),
      .fifo_depth(depth),
      .total_size(ts)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bit_count(bit_count),
      .done(done),
      .clr(clr),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .rd_valid(rd_valid),
      .empty(empty),
      .full(full),
      .level(level),
      .overflow(overflow)
`ifdef ONES_TOTAL_EN
      ,
      .total(total)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".level"}, 32'(level), 32'(mlevel));
      check({tag, ".empty"}, 32'(empty), 32'(mlevel == 0));
      check({tag, ".full"}, 32'(full), 32'(mlevel == depth));
      check({tag, ".overflow"}, 32'(overflow), 32'(movf));
   endtask

   task automatic capture(input logic [cs-1:0] v);
      bit_count = v;
      done = 1'b1;
      if (mlevel < depth) begin
         sb.push_back(v);
         mlevel++;
      end else begin
         movf = 1'b1;
      end
      tick();
      done = 1'b0;
      tick();
   endtask

   task automatic pop_one(input string tag);
      logic [cs-1:0] exp;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      exp = sb.pop_front();
      mlevel--;
      mlast = exp;
      check({tag, ".rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, ".rd_data"}, 32'(rd_data), 32'(exp));
      tick();
      check({tag, ".rd_valid_drop"}, 32'(rd_valid), 32'd0);
   endtask

   initial begin
      // reset state
      tick();
      check("rst.rd_data", 32'(rd_data), 32'd0);
      check("rst.rd_valid", 32'(rd_valid), 32'd0);
      check_state("rst");
      reset = 1'b1;
      tick();
      tick();

      // single capture held high for three cycles, then pop
      bit_count = 3'd4;
      done = 1'b1;
      sb.push_back(3'd4);
      mlevel = 1;
      tick();
      tick();
      tick();
      check_state("hold3");
      done = 1'b0;
      tick();
      check_state("hold3_low");
      pop_one("pop4");
      check_state("after_pop4");

      // read while empty is ignored
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      check("empty_rd.rd_valid", 32'(rd_valid), 32'd0);
      check("empty_rd.rd_data", 32'(rd_data), 32'(mlast));

      // fill, overflow, drain
      capture(3'd1);
      capture(3'd2);
      capture(3'd3);
      capture(3'd4);
      check_state("full4");
      capture(3'd2);
      check_state("drop");
      for (int i = 0; i < depth; i++) pop_one("drain");
      check_state("drained");
      clr = 1'b1;
      tick();
      clr = 1'b0;
      movf = 1'b0;
      check_state("clr1");

      // capture and pop together while full
      capture(3'd5);
      capture(3'd6);
      capture(3'd7);
      capture(3'd1);
      bit_count = 3'd3;
      done = 1'b1;
      rd_en = 1'b1;
      tick();
      done = 1'b0;
      rd_en = 1'b0;
      check("fullsim.rd_valid", 32'(rd_valid), 32'd1);
      check("fullsim.rd_data", 32'(rd_data), 32'(sb.pop_front()));
      sb.push_back(3'd3);
      check_state("fullsim");
      tick();
      for (int i = 0; i < depth; i++) pop_one("wrap");
      check("last_pop_is_3", 32'(mlast), 32'd3);
      check_state("wrap_empty");

      // capture into empty with rd_en: push only, no bypass
      bit_count = 3'd2;
      done = 1'b1;
      rd_en = 1'b1;
      tick();
      done = 1'b0;
      rd_en = 1'b0;
      sb.push_back(3'd2);
      mlevel = 1;
      check("nobypass.rd_valid", 32'(rd_valid), 32'd0);
      check("nobypass.rd_data", 32'(rd_data), 32'(mlast));
      check_state("nobypass");
      tick();

      // capture and pop together at partial level
      bit_count = 3'd6;
      done = 1'b1;
      rd_en = 1'b1;
      tick();
      done = 1'b0;
      rd_en = 1'b0;
      check("midsim.rd_valid", 32'(rd_valid), 32'd1);
      check("midsim.rd_data", 32'(rd_data), 32'(sb.pop_front()));
      sb.push_back(3'd6);
      check_state("midsim");
      tick();
      pop_one("pop6");

      // two entries plus overflow, then clr with rd_en
      for (int i = 0; i < 5; i++) capture(3'(i + 1));
      pop_one("pre_clr_a");
      pop_one("pre_clr_b");
      check_state("pre_clr");
      clr = 1'b1;
      rd_en = 1'b1;
      tick();
      clr = 1'b0;
      rd_en = 1'b0;
      sb.delete();
      mlevel = 0;
      movf = 1'b0;
      check_state("clr_rd");
      check("clr_rd.rd_valid", 32'(rd_valid), 32'd0);
      check("clr_rd.rd_data", 32'(rd_data), 32'(mlast));

`ifdef ONES_TOTAL_EN
      check("total_clr", 32'(total), 32'd0);
      capture(3'd4);
      pop_one("t1");
      check("total_4", 32'(total), 32'd4);
      capture(3'd4);
      pop_one("t2");
      check("total_8", 32'(total), 32'd8);
      capture(3'd4);
      pop_one("t3");
      check("total_12", 32'(total), 32'd12);
      capture(3'd4);
      pop_one("t4");
      check("total_sat", 32'(total), 32'd15);
`endif

      // asynchronous reset between edges, done held across release
      capture(3'd3);
      capture(3'd5);
      check_state("pre_async");
      #3;
      reset = 1'b0;
      #1;
      sb.delete();
      mlevel = 0;
      movf = 1'b0;
      check("async.rd_data", 32'(rd_data), 32'd0);
      check("async.rd_valid", 32'(rd_valid), 32'd0);
      check_state("async");
      done = 1'b1;
      bit_count = 3'd7;
      tick();
      reset = 1'b1;
      tick();
      tick();
      tick();
      check_state("done_across_release");
      done = 1'b0;
      tick();
      capture(3'd7);
      check_state("post_release_cap");
      pop_one("pop7");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
